vc_writer: RTL and testbench

- Write-side counterpart of the virtual-channel arbiter.
- Pops packets from the single ingress FIFO and routes each one into one of four virtual-channel FIFOs (VC0..VC3), using the destination field carried in the packet.
- Honors per-VC full backpressure with head-of-line stall.
- Keeps per-VC packet counters for the verification scoreboard.

---
 rtl/vc_writer.sv | 118 +++++++++++
 tb/tb_vc_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_writer.sv
// vc_writer: pops packets from a show-ahead ingress FIFO and routes each one
// into one of four virtual-channel FIFOs selected by the top two data bits.
// A single hold register decouples the ingress pop from the VC push.
// Head-of-line stall on a full VC. Per-VC packet counters wrap silently.
module vc_writer #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_pop,
    input  logic                  full_vchannel0,
    input  logic                  full_vchannel1,
    input  logic                  full_vchannel2,
    input  logic                  full_vchannel3,
    output logic                  push_vchannel0,
    output logic                  push_vchannel1,
    output logic                  push_vchannel2,
    output logic                  push_vchannel3,
    output logic [DATA_WIDTH-1:0] data_vchannel,
    output logic [CNT_WIDTH-1:0]  cnt_vchannel0,
    output logic [CNT_WIDTH-1:0]  cnt_vchannel1,
    output logic [CNT_WIDTH-1:0]  cnt_vchannel2,
    output logic [CNT_WIDTH-1:0]  cnt_vchannel3,
    output logic [1:0]            state,
    output logic                  idle
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01,
        STALL  = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [3:0]            push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];

    logic [3:0]            full_vec;
    logic [1:0]            dest;
    logic [1:0]            dest_d;
    logic                  fire;

    assign full_vec = {full_vchannel3, full_vchannel2, full_vchannel1, full_vchannel0};
    assign dest     = hold_data_q[DATA_WIDTH-1 -: 2];

    // The held packet leaves whenever its VC has room; a pop may refill the
    // hold register in the same cycle it drains, giving one packet per cycle.
    assign fire   = enb & hold_valid_q & ~full_vec[dest];
    assign in_pop = enb & ~rst & ~in_empty & (~hold_valid_q | fire);

    // Next hold contents and the FSM class derived from them.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        state_d      = IDLE;
        if (in_pop) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end
        dest_d = hold_data_d[DATA_WIDTH-1 -: 2];
        if (hold_valid_d) begin
            state_d = full_vec[dest_d] ? STALL : LOADED;
        end
    end

    // Hold register, FSM state, push strobes, write data and counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            push_q       <= '0;
            data_q       <= '0;
            // NOTE: the counter array is small and architecturally visible,
            // so it is cleared explicitly rather than left to power-up value.
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            push_q <= fire ? (4'b0001 << dest) : 4'b0000;
            if (fire) begin
                data_q      <= hold_data_q;
                cnt_q[dest] <= cnt_q[dest] + 1'b1;
            end
            if (enb) begin
                hold_data_q  <= hold_data_d;
                hold_valid_q <= hold_valid_d;
                state_q      <= state_d;
            end
        end
    end

    assign push_vchannel0 = push_q[0];
    assign push_vchannel1 = push_q[1];
    assign push_vchannel2 = push_q[2];
    assign push_vchannel3 = push_q[3];
    assign data_vchannel  = data_q;
    assign cnt_vchannel0  = cnt_q[0];
    assign cnt_vchannel1  = cnt_q[1];
    assign cnt_vchannel2  = cnt_q[2];
    assign cnt_vchannel3  = cnt_q[3];
    assign state          = state_q;
    assign idle           = (state_q == IDLE) && in_empty;

endmodule

// File: tb/tb_vc_writer.sv
// Self-checking bench for vc_writer: a table-driven routing test, directed
// corner sequences, then random traffic, all shadowed by a packet-level model.
module tb_vc_writer;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          in_empty;
    logic [DW-1:0] in_data;
    logic          in_pop;
    logic [3:0]    full;
    logic          push0, push1, push2, push3;
    logic [DW-1:0] data_vc;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [1:0]    state;
    logic          idle;

    vc_writer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enb            (enb),
        .in_empty       (in_empty),
        .in_data        (in_data),
        .in_pop         (in_pop),
        .full_vchannel0 (full[0]),
        .full_vchannel1 (full[1]),
        .full_vchannel2 (full[2]),
        .full_vchannel3 (full[3]),
        .push_vchannel0 (push0),
        .push_vchannel1 (push1),
        .push_vchannel2 (push2),
        .push_vchannel3 (push3),
        .data_vchannel  (data_vc),
        .cnt_vchannel0  (cnt0),
        .cnt_vchannel1  (cnt1),
        .cnt_vchannel2  (cnt2),
        .cnt_vchannel3  (cnt3),
        .state          (state),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    logic [3:0]    push_vec;
    logic [CW-1:0] cnt_vec [4];
    assign push_vec   = {push3, push2, push1, push0};
    assign cnt_vec[0] = cnt0;
    assign cnt_vec[1] = cnt1;
    assign cnt_vec[2] = cnt2;
    assign cnt_vec[3] = cnt3;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ingress FIFO contents, one held packet, the last
    // packet handed to the VCs and a packet count per VC.
    logic [DW-1:0] fifo [$];
    bit            m_known = 1'b0;
    bit            m_valid;
    logic [DW-1:0] m_hold;
    logic [3:0]    m_push;
    logic [DW-1:0] m_dout;
    int            m_cnt [4];
    logic [1:0]    m_state;
    logic          pre_pop;

    // One clock cycle: present the FIFO head, check combinational outputs,
    // advance the model across the edge, then check registered outputs.
    task automatic tick();
        bit fire;
        bit pop;
        int d;
        in_empty = (fifo.size() == 0);
        in_data  = (fifo.size() == 0) ? '0 : fifo[0];
        #1;
        d    = int'(m_hold[DW-1 -: 2]);
        fire = enb && m_valid && !full[d];
        pop  = enb && !rst && (fifo.size() != 0) && (!m_valid || fire);
        pre_pop = in_pop;
        check("in_pop", 32'(in_pop), 32'(pop));
        if (m_known) check("idle", 32'(idle), 32'((m_state == 2'b00) && (fifo.size() == 0)));
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_push  = '0;
            m_dout  = '0;
            m_state = 2'b00;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            m_push = fire ? (4'b0001 << d) : 4'b0000;
            if (fire) begin
                m_dout   = m_hold;
                m_cnt[d] = (m_cnt[d] + 1) % 32;
            end
            if (enb) begin
                if (pop) begin
                    m_valid = 1'b1;
                    m_hold  = fifo.pop_front();
                end else if (fire) begin
                    m_valid = 1'b0;
                end
                if (!m_valid) m_state = 2'b00;
                else m_state = full[m_hold[DW-1 -: 2]] ? 2'b10 : 2'b01;
            end
        end
        #1;
        if (m_known) begin
            check("push", 32'(push_vec), 32'(m_push));
            check("data", 32'(data_vc), 32'(m_dout));
            check("state", 32'(state), 32'(m_state));
            for (int i = 0; i < 4; i++) check($sformatf("cnt%0d", i), 32'(cnt_vec[i]), 32'(m_cnt[i]));
        end
    endtask

    typedef struct {
        logic       enb;
        logic [3:0] full;
        logic       exp_pop;
        logic [3:0] exp_push;
        logic [5:0] exp_data;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl [6];
    int   seen1;
    int   seen2;

    initial begin
        // Back-to-back routing: expected per-cycle pop, then post-edge outputs.
        tbl[0] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 6'h00, 2'b01};
        tbl[1] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 6'h05, 2'b01};
        tbl[2] = '{1'b1, 4'b0000, 1'b1, 4'b0010, 6'h1A, 2'b01};
        tbl[3] = '{1'b1, 4'b0000, 1'b1, 4'b0100, 6'h23, 2'b01};
        tbl[4] = '{1'b1, 4'b0000, 1'b0, 4'b1000, 6'h3F, 2'b00};
        tbl[5] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 6'h3F, 2'b00};

        // 1. Reset then idle.
        rst = 1'b1; enb = 1'b1; full = 4'b0000;
        tick();
        tick();
        check("t1_idle", 32'(idle), 32'd1);
        check("t1_state", 32'(state), 32'd0);
        check("t1_data", 32'(data_vc), 32'd0);
        rst = 1'b0;

        // 2. Back-to-back routing, table driven.
        fifo.push_back(6'h05);
        fifo.push_back(6'h1A);
        fifo.push_back(6'h23);
        fifo.push_back(6'h3F);
        for (int i = 0; i < 6; i++) begin
            enb  = tbl[i].enb;
            full = tbl[i].full;
            tick();
            check($sformatf("t2_pop[%0d]", i), 32'(pre_pop), 32'(tbl[i].exp_pop));
            check($sformatf("t2_push[%0d]", i), 32'(push_vec), 32'(tbl[i].exp_push));
            check($sformatf("t2_data[%0d]", i), 32'(data_vc), 32'(tbl[i].exp_data));
            check($sformatf("t2_state[%0d]", i), 32'(state), 32'(tbl[i].exp_state));
        end
        for (int i = 0; i < 4; i++) check($sformatf("t2_cnt%0d", i), 32'(cnt_vec[i]), 32'd1);

        // 3. Stall on full VC2, then release.
        full = 4'b0100;
        fifo.push_back(6'h21);
        fifo.push_back(6'h02);
        tick();
        check("t3_state_a", 32'(state), 32'd2);
        repeat (2) begin
            tick();
            check("t3_stall_pop", 32'(pre_pop), 32'd0);
            check("t3_stall_push", 32'(push_vec), 32'd0);
            check("t3_stall_state", 32'(state), 32'd2);
        end
        full = 4'b0000;
        tick();
        check("t3_push2", 32'(push_vec), 32'b0100);
        check("t3_data21", 32'(data_vc), 32'h21);
        tick();
        check("t3_push0", 32'(push_vec), 32'b0001);
        check("t3_data02", 32'(data_vc), 32'h02);
        check("t3_cnt2", 32'(cnt2), 32'd2);
        check("t3_cnt0", 32'(cnt0), 32'd2);
        tick();

        // 4. Enable dropped for three cycles mid-stream.
        fifo.push_back(6'h07);
        fifo.push_back(6'h18);
        fifo.push_back(6'h2C);
        tick();
        tick();
        check("t4_push07", 32'(push_vec), 32'b0001);
        enb = 1'b0;
        repeat (3) begin
            tick();
            check("t4_off_pop", 32'(pre_pop), 32'd0);
            check("t4_off_push", 32'(push_vec), 32'd0);
            check("t4_off_data", 32'(data_vc), 32'h07);
            check("t4_off_cnt0", 32'(cnt0), 32'd3);
        end
        enb = 1'b1;
        tick();
        check("t4_push18", 32'(push_vec), 32'b0010);
        check("t4_data18", 32'(data_vc), 32'h18);
        tick();
        check("t4_push2C", 32'(push_vec), 32'b0100);
        check("t4_cnt1", 32'(cnt1), 32'd2);
        check("t4_cnt2", 32'(cnt2), 32'd3);
        tick();

        // 5. Counter wrap on VC3.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 33; i++) fifo.push_back(6'h30 | 6'(i % 16));
        repeat (36) tick();
        check("t5_cnt3", 32'(cnt3), 32'd1);
        check("t5_cnt0", 32'(cnt0), 32'd0);
        check("t5_cnt1", 32'(cnt1), 32'd0);
        check("t5_cnt2", 32'(cnt2), 32'd0);

        // 6. Reset while stalled: held packet is dropped, no partial push.
        full = 4'b0010;
        fifo.push_back(6'h11);
        tick();
        tick();
        check("t6_stall", 32'(state), 32'd2);
        fifo.push_back(6'h22);
        rst  = 1'b1;
        full = 4'b0000;
        tick();
        check("t6_rst_pop", 32'(pre_pop), 32'd0);
        check("t6_rst_push", 32'(push_vec), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_cnt1", 32'(cnt1), 32'd0);
        rst   = 1'b0;
        seen1 = 0;
        seen2 = 0;
        repeat (4) begin
            tick();
            seen1 += int'(push1);
            seen2 += int'(push2);
        end
        check("t6_no_vc1", 32'(seen1), 32'd0);
        check("t6_vc2_once", 32'(seen2), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            rst  = ($urandom_range(0, 99) < 2);
            enb  = ($urandom_range(0, 99) < 90);
            for (int v = 0; v < 4; v++) full[v] = ($urandom_range(0, 99) < 25);
            if (fifo.size() < 8 && $urandom_range(0, 99) < 70) fifo.push_back(6'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
